// File: rtl/sim_tape_device.sv
// sim_tape_device: simulation-side 5-hole tape reader/punch for the SoC device port.
// A bench-loaded input FIFO feeds dev_input_* one character at a time with a
// mechanical gap between characters. A capture FIFO acknowledges and stores
// dev_output_* characters, one per dev_output_rdy assertion.
// Optional build macro SIM_TAPE_COUNTERS_EN adds the in_xfer_cnt/out_xfer_cnt
// transfer counters and the sticky ld_drop flag.
module sim_tape_device #(
    parameter int DATA_W     = 5,
    parameter int IN_DEPTH   = 16,
    parameter int OUT_DEPTH  = 16,
    parameter int GAP_CYCLES = 4
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             ld_val,
    input  logic [DATA_W-1:0]                ld_data,
    output logic                             ld_rdy,
    output logic                             dev_input_val,
    output logic [DATA_W-1:0]                dev_input_data,
    input  logic                             dev_input_rdy,
    input  logic                             dev_output_rdy,
    input  logic [DATA_W-1:0]                dev_output_data,
    output logic                             dev_output_ack,
    output logic                             cap_val,
    output logic [DATA_W-1:0]                cap_data,
    input  logic                             cap_pop,
    output logic [$clog2(IN_DEPTH+1)-1:0]    in_level,
    output logic [$clog2(OUT_DEPTH+1)-1:0]   cap_level
`ifdef SIM_TAPE_COUNTERS_EN
    ,
    output logic [15:0]                      in_xfer_cnt,
    output logic [15:0]                      out_xfer_cnt,
    output logic                             ld_drop
`endif
);

    localparam int IN_LW  = $clog2(IN_DEPTH + 1);
    localparam int IN_PW  = $clog2(IN_DEPTH);
    localparam int OUT_LW = $clog2(OUT_DEPTH + 1);
    localparam int OUT_PW = $clog2(OUT_DEPTH);
    localparam int GW     = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IN_IDLE, IN_PRESENT, IN_GAP} in_state_t;
    typedef enum logic [1:0] {O_IDLE, O_WAIT, O_ACK, O_RELEASE} out_state_t;

    // ------------------------------------------------------------------
    // Input FIFO (bench -> reader)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] in_mem [IN_DEPTH];
    logic [IN_PW-1:0]  in_wr_ptr_reg, in_rd_ptr_reg;
    logic [IN_LW-1:0]  in_cnt_reg, in_cnt_next;
    logic              ld_rdy_reg;
    logic              in_full, in_push, in_pop;

    in_state_t         in_state_reg;
    logic              in_val_reg;
    logic [DATA_W-1:0] in_data_reg;
    logic [GW-1:0]     in_gap_reg;

    // A push while full is dropped even if the head leaves in the same cycle.
    assign in_full     = (in_cnt_reg == IN_LW'(IN_DEPTH));
    assign in_push     = ld_val && !in_full;
    assign in_pop      = (in_state_reg == IN_PRESENT) && dev_input_rdy;
    assign in_cnt_next = in_cnt_reg + IN_LW'(in_push) - IN_LW'(in_pop);

    // Input FIFO storage write port
    always_ff @(posedge clk) begin
        if (in_push)
            in_mem[in_wr_ptr_reg] <= ld_data;
    end

    // Input FIFO pointers, occupancy and registered ready
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            in_wr_ptr_reg <= '0;
            in_rd_ptr_reg <= '0;
            in_cnt_reg    <= '0;
            ld_rdy_reg    <= 1'b1;
        end else begin
            if (in_push)
                in_wr_ptr_reg <= in_wr_ptr_reg + IN_PW'(1);
            if (in_pop)
                in_rd_ptr_reg <= in_rd_ptr_reg + IN_PW'(1);
            in_cnt_reg <= in_cnt_next;
            ld_rdy_reg <= (in_cnt_next != IN_LW'(IN_DEPTH));
        end
    end

    // Reader FSM: present head, hold it until taken, then idle for the gap.
    // The gap counts the IDLE hop as one of its low cycles, so val stays low
    // for GAP_CYCLES cycles (at least one) between characters.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            in_state_reg <= IN_IDLE;
            in_val_reg   <= 1'b0;
            in_data_reg  <= '0;
            in_gap_reg   <= '0;
        end else begin
            case (in_state_reg)
                IN_IDLE: begin
                    if (in_cnt_reg != '0) begin
                        in_state_reg <= IN_PRESENT;
                        in_val_reg   <= 1'b1;
                        in_data_reg  <= in_mem[in_rd_ptr_reg];
                    end
                end
                IN_PRESENT: begin
                    if (dev_input_rdy) begin
                        in_val_reg <= 1'b0;
                        in_gap_reg <= GW'(1);
                        if (GAP_CYCLES <= 1)
                            in_state_reg <= IN_IDLE;
                        else
                            in_state_reg <= IN_GAP;
                    end
                end
                IN_GAP: begin
                    if (int'(in_gap_reg) >= GAP_CYCLES - 1)
                        in_state_reg <= IN_IDLE;
                    else
                        in_gap_reg <= in_gap_reg + GW'(1);
                end
                default: begin
                    in_state_reg <= IN_IDLE;
                    in_val_reg   <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Capture FIFO (punch -> bench)
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] cap_mem [OUT_DEPTH];
    logic [OUT_PW-1:0] cap_wr_ptr_reg, cap_rd_ptr_reg, cap_rd_next;
    logic [OUT_LW-1:0] cap_cnt_reg, cap_cnt_next;
    logic              cap_val_reg;
    logic [DATA_W-1:0] cap_data_reg;
    logic              cap_full, cap_push, cap_take;

    out_state_t        out_state_reg;
    logic              ack_reg;
    logic [GW-1:0]     out_gap_reg;

    // The character is stored in the cycle after the ack pulse; the ACK
    // state is only entered with space available, so the push always fits.
    assign cap_full     = (cap_cnt_reg == OUT_LW'(OUT_DEPTH));
    assign cap_push     = (out_state_reg == O_ACK);
    assign cap_take     = cap_pop && (cap_cnt_reg != '0);
    assign cap_cnt_next = cap_cnt_reg + OUT_LW'(cap_push) - OUT_LW'(cap_take);
    assign cap_rd_next  = cap_take ? cap_rd_ptr_reg + OUT_PW'(1) : cap_rd_ptr_reg;

    // Capture FIFO storage write port
    always_ff @(posedge clk) begin
        if (cap_push)
            cap_mem[cap_wr_ptr_reg] <= dev_output_data;
    end

    // Capture FIFO pointers plus registered head/valid, computed from the
    // post-edge state so cap_data always shows the new head.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cap_wr_ptr_reg <= '0;
            cap_rd_ptr_reg <= '0;
            cap_cnt_reg    <= '0;
            cap_val_reg    <= 1'b0;
            cap_data_reg   <= '0;
        end else begin
            if (cap_push)
                cap_wr_ptr_reg <= cap_wr_ptr_reg + OUT_PW'(1);
            cap_rd_ptr_reg <= cap_rd_next;
            cap_cnt_reg    <= cap_cnt_next;
            cap_val_reg    <= (cap_cnt_next != '0);
            if (cap_cnt_next == '0)
                cap_data_reg <= '0;
            else if (cap_push && (cap_wr_ptr_reg == cap_rd_next))
                cap_data_reg <= dev_output_data;
            else
                cap_data_reg <= cap_mem[cap_rd_next];
        end
    end

    // Punch FSM: wait out the gap while rdy holds, ack once (stalling while
    // the capture FIFO is full), then wait for rdy to drop before re-arming.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_state_reg <= O_IDLE;
            ack_reg       <= 1'b0;
            out_gap_reg   <= '0;
        end else begin
            case (out_state_reg)
                O_IDLE: begin
                    if (dev_output_rdy) begin
                        out_state_reg <= O_WAIT;
                        out_gap_reg   <= '0;
                    end
                end
                O_WAIT: begin
                    if (!dev_output_rdy) begin
                        out_state_reg <= O_IDLE;
                    end else if (int'(out_gap_reg) < GAP_CYCLES) begin
                        out_gap_reg <= out_gap_reg + GW'(1);
                    end else if (!cap_full) begin
                        out_state_reg <= O_ACK;
                        ack_reg       <= 1'b1;
                    end
                end
                O_ACK: begin
                    ack_reg       <= 1'b0;
                    out_state_reg <= O_RELEASE;
                end
                O_RELEASE: begin
                    if (!dev_output_rdy)
                        out_state_reg <= O_IDLE;
                end
                default: begin
                    out_state_reg <= O_IDLE;
                    ack_reg       <= 1'b0;
                end
            endcase
        end
    end

`ifdef SIM_TAPE_COUNTERS_EN
    logic [15:0] in_xfer_reg, out_xfer_reg;
    logic        ld_drop_reg;

    // Transfer counters (wrap naturally) and sticky dropped-load flag
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            in_xfer_reg  <= '0;
            out_xfer_reg <= '0;
            ld_drop_reg  <= 1'b0;
        end else begin
            in_xfer_reg  <= in_xfer_reg + 16'(in_pop);
            out_xfer_reg <= out_xfer_reg + 16'(cap_push);
            ld_drop_reg  <= ld_drop_reg | (ld_val & in_full);
        end
    end

    assign in_xfer_cnt  = in_xfer_reg;
    assign out_xfer_cnt = out_xfer_reg;
    assign ld_drop      = ld_drop_reg;
`endif

    assign ld_rdy         = ld_rdy_reg;
    assign dev_input_val  = in_val_reg;
    assign dev_input_data = in_data_reg;
    assign dev_output_ack = ack_reg;
    assign cap_val        = cap_val_reg;
    assign cap_data       = cap_data_reg;
    assign in_level       = in_cnt_reg;
    assign cap_level      = cap_cnt_reg;

endmodule

// File: tb/tb_sim_tape_device.sv
// tb_sim_tape_device: directed table/sequence tests plus randomized traffic
// for sim_tape_device, checked against a queue-based behavioural model.
`timescale 1ns/1ps
module tb_sim_tape_device;

    localparam int DW  = 5;
    localparam int D   = 16;
    localparam int OD  = 16;
    localparam int G   = 4;
    localparam int ILW = $clog2(D + 1);
    localparam int OLW = $clog2(OD + 1);

    logic            clk = 1'b0;
    logic            resetn = 1'b0;
    logic            ld_val = 1'b0;
    logic [DW-1:0]   ld_data = '0;
    logic            ld_rdy;
    logic            dev_input_val;
    logic [DW-1:0]   dev_input_data;
    logic            dev_input_rdy = 1'b0;
    logic            dev_output_rdy = 1'b0;
    logic [DW-1:0]   dev_output_data = '0;
    logic            dev_output_ack;
    logic            cap_val;
    logic [DW-1:0]   cap_data;
    logic            cap_pop = 1'b0;
    logic [ILW-1:0]  in_level;
    logic [OLW-1:0]  cap_level;
`ifdef SIM_TAPE_COUNTERS_EN
    logic [15:0]     in_xfer_cnt, out_xfer_cnt;
    logic            ld_drop;
`endif

    sim_tape_device #(.DATA_W(DW), .IN_DEPTH(D), .OUT_DEPTH(OD), .GAP_CYCLES(G)) dut (
        .clk(clk), .resetn(resetn),
        .ld_val(ld_val), .ld_data(ld_data), .ld_rdy(ld_rdy),
        .dev_input_val(dev_input_val), .dev_input_data(dev_input_data),
        .dev_input_rdy(dev_input_rdy),
        .dev_output_rdy(dev_output_rdy), .dev_output_data(dev_output_data),
        .dev_output_ack(dev_output_ack),
        .cap_val(cap_val), .cap_data(cap_data), .cap_pop(cap_pop),
        .in_level(in_level), .cap_level(cap_level)
`ifdef SIM_TAPE_COUNTERS_EN
        , .in_xfer_cnt(in_xfer_cnt), .out_xfer_cnt(out_xfer_cnt), .ld_drop(ld_drop)
`endif
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: queues of characters in flight on each side.
    logic [DW-1:0] in_q[$];
    logic [DW-1:0] cap_q[$];
    logic [DW-1:0] recv_q[$];
    int            rise_t[$];
    int            ack_t[$];
    int            cyc = 0;
    int            ack_cnt = 0;
    bit            mon_en = 0;
    bit            prev_val = 0;
    bit            prev_ack = 0;
    bit            out_acked = 0;
    int            xfer_m = 0;
    int            oxfer_m = 0;
    bit            drop_m = 0;

    always @(posedge clk) cyc++;

    // Per-cycle model comparison and event bookkeeping, away from the edge.
    always @(negedge clk) begin
        if (mon_en) begin
            bit in_was_full;
            bit take;
            chk("in_level", 32'(in_level), 32'(in_q.size()));
            chk("ld_rdy", 32'(ld_rdy), 32'(in_q.size() < D));
            chk("cap_level", 32'(cap_level), 32'(cap_q.size()));
            chk("cap_val", 32'(cap_val), 32'(cap_q.size() != 0));
            if (cap_q.size() != 0)
                chk("cap_data", 32'(cap_data), 32'(cap_q[0]));
            chk("val_needs_entry", 32'(dev_input_val && in_q.size() == 0), 32'(0));
            if (dev_input_val && in_q.size() != 0)
                chk("in_data", 32'(dev_input_data), 32'(in_q[0]));
`ifdef SIM_TAPE_COUNTERS_EN
            chk("in_xfer_cnt", 32'(in_xfer_cnt), 32'(xfer_m & 16'hFFFF));
            chk("out_xfer_cnt", 32'(out_xfer_cnt), 32'(oxfer_m & 16'hFFFF));
            chk("ld_drop", 32'(ld_drop), 32'(drop_m));
`endif
            if (dev_input_val && !prev_val)
                rise_t.push_back(cyc);
            in_was_full = (in_q.size() >= D);
            if (dev_input_val && dev_input_rdy && in_q.size() != 0) begin
                recv_q.push_back(dev_input_data);
                void'(in_q.pop_front());
                xfer_m++;
            end
            if (ld_val) begin
                if (in_was_full) drop_m = 1;
                else in_q.push_back(ld_data);
            end
            take = cap_pop && (cap_q.size() != 0);
            if (take) void'(cap_q.pop_front());
            if (dev_output_ack) begin
                chk("ack_one_cycle", 32'(prev_ack), 32'(0));
                ack_t.push_back(cyc);
                ack_cnt++;
                oxfer_m++;
                out_acked = 1;
                cap_q.push_back(dev_output_data);
            end
            prev_val = dev_input_val;
            prev_ack = dev_output_ack;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        in_q.delete(); cap_q.delete(); recv_q.delete(); rise_t.delete(); ack_t.delete();
        prev_val = 0; prev_ack = 0; xfer_m = 0; oxfer_m = 0; drop_m = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ld_rdy"}, 32'(ld_rdy), 32'(1));
        chk({tag, "_val"}, 32'(dev_input_val), 32'(0));
        chk({tag, "_in_data"}, 32'(dev_input_data), 32'(0));
        chk({tag, "_ack"}, 32'(dev_output_ack), 32'(0));
        chk({tag, "_cap_val"}, 32'(cap_val), 32'(0));
        chk({tag, "_cap_data"}, 32'(cap_data), 32'(0));
        chk({tag, "_in_level"}, 32'(in_level), 32'(0));
        chk({tag, "_cap_level"}, 32'(cap_level), 32'(0));
    endtask

    typedef struct packed {
        logic [DW-1:0] ld;
        logic [DW-1:0] exp;
    } vec_t;

    initial begin
        vec_t vt[3];
        int   t0, n, r;
        vt[0] = '{ld: 5'h01, exp: 5'h01};
        vt[1] = '{ld: 5'h1F, exp: 5'h1F};
        vt[2] = '{ld: 5'h0A, exp: 5'h0A};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        resetn = 1'b1;
        tick();
        mon_en = 1;

        // Table: three characters through the reader with rdy held high
        dev_input_rdy = 1'b1;
        t0 = cyc;
        for (int i = 0; i < 3; i++) begin
            ld_val = 1'b1; ld_data = vt[i].ld;
            tick();
        end
        ld_val = 1'b0;
        for (int k = 0; k < 60 && recv_q.size() < 3; k++) tick();
        chk("t1_recv_count", 32'(recv_q.size()), 32'(3));
        for (int i = 0; i < 3; i++)
            if (i < recv_q.size())
                chk($sformatf("t1_data%0d", i), 32'(recv_q[i]), 32'(vt[i].exp));
        if (rise_t.size() >= 3) begin
            chk("t1_load_to_val", 32'(rise_t[0] - t0), 32'(2));
            for (int i = 1; i < 3; i++)
                chk($sformatf("t1_spacing%0d", i), 32'(rise_t[i] - rise_t[i-1]), 32'(G + 1));
        end else begin
            chk("t1_rise_count", 32'(rise_t.size()), 32'(3));
        end
        tick();
        chk("t1_in_level", 32'(in_level), 32'(0));

        // Held character while the SoC stalls
        dev_input_rdy = 1'b0;
        repeat (8) tick();
        ld_val = 1'b1; ld_data = 5'h15;
        tick();
        ld_val = 1'b0;
        for (int k = 0; k < 5 && !dev_input_val; k++) tick();
        n = recv_q.size();
        for (int k = 0; k < 20; k++) begin
            if (k % 5 == 0) begin
                chk("t2_val_held", 32'(dev_input_val), 32'(1));
                chk("t2_data_held", 32'(dev_input_data), 32'(5'h15));
            end
            tick();
        end
        dev_input_rdy = 1'b1;
        tick();
        dev_input_rdy = 1'b0;
        chk("t2_xfer_first_rdy", 32'(recv_q.size() - n), 32'(1));
        if (recv_q.size() > n) chk("t2_xfer_data", 32'(recv_q[n]), 32'(5'h15));
        chk("t2_val_dropped", 32'(dev_input_val), 32'(0));
        repeat (G + 2) tick();

        // Overfill the input FIFO
        for (int i = 0; i < 17; i++) begin
            ld_val = 1'b1; ld_data = DW'(i + 3);
            tick();
            if (i == 15) begin
                chk("t3_ld_rdy_full", 32'(ld_rdy), 32'(0));
                chk("t3_level_full", 32'(in_level), 32'(D));
`ifdef SIM_TAPE_COUNTERS_EN
                chk("t3_no_drop_yet", 32'(ld_drop), 32'(0));
`endif
            end
        end
        ld_val = 1'b0;
        tick();
        chk("t3_level_after_drop", 32'(in_level), 32'(D));
`ifdef SIM_TAPE_COUNTERS_EN
        chk("t3_ld_drop", 32'(ld_drop), 32'(1));
`endif
        dev_input_rdy = 1'b1;
        for (int k = 0; k < 200 && in_q.size() != 0; k++) tick();
        dev_input_rdy = 1'b0;
        chk("t3_drained", 32'(in_q.size()), 32'(0));
        repeat (G + 2) tick();

        // Single capture with ack latency, no re-capture while rdy held
        n = ack_cnt;
        dev_output_data = 5'h13; dev_output_rdy = 1'b1;
        r = cyc;
        for (int k = 0; k < 20 && ack_cnt == n; k++) tick();
        chk("t4_acked", 32'(ack_cnt - n), 32'(1));
        if (ack_t.size() != 0) chk("t4_ack_latency", 32'(ack_t[$] - r), 32'(G + 2));
        chk("t4_cap_val", 32'(cap_val), 32'(1));
        chk("t4_cap_data", 32'(cap_data), 32'(5'h13));
        repeat (20) tick();
        chk("t4_single_capture", 32'(ack_cnt - n), 32'(1));
        dev_output_rdy = 1'b0;
        repeat (2) tick();
        cap_pop = 1'b1; tick(); cap_pop = 1'b0;
        tick();
        chk("t4_cap_emptied", 32'(cap_level), 32'(0));

        // Fill capture FIFO, then backpressure and release by one pop
        for (int i = 0; i < OD; i++) begin
            n = ack_cnt;
            dev_output_data = DW'($urandom); dev_output_rdy = 1'b1;
            for (int k = 0; k < 20 && ack_cnt == n; k++) tick();
            chk("t5_fill_ack", 32'(ack_cnt - n), 32'(1));
            tick();
            dev_output_rdy = 1'b0;
            repeat (2) tick();
        end
        chk("t5_cap_full", 32'(cap_level), 32'(OD));
        n = ack_cnt;
        dev_output_data = 5'h07; dev_output_rdy = 1'b1;
        repeat (30) tick();
        chk("t5_no_ack_when_full", 32'(ack_cnt - n), 32'(0));
        cap_pop = 1'b1; tick(); cap_pop = 1'b0;
        for (int k = 0; k < 10 && ack_cnt == n; k++) tick();
        chk("t5_ack_after_pop", 32'(ack_cnt - n), 32'(1));
        tick();
        dev_output_rdy = 1'b0;
        tick();
        for (int i = 0; i < OD; i++) begin
            if (i == OD - 1) chk("t5_last_is_07", 32'(cap_data), 32'(5'h07));
            cap_pop = 1'b1;
            tick();
        end
        cap_pop = 1'b0;
        tick();
        chk("t5_cap_drained", 32'(cap_level), 32'(0));

        // Reset during input GAP and output WAIT
        dev_input_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ld_val = 1'b1; ld_data = DW'(5'h0A + i);
            if (i == 1) begin dev_output_data = 5'h11; dev_output_rdy = 1'b1; end
            tick();
        end
        ld_val = 1'b0;
        tick();
        mon_en = 0;
        resetn = 1'b0;
        #2;
        chk_reset_outputs("t6_async");
        dev_output_rdy = 1'b0; dev_input_rdy = 1'b0;
        model_reset();
        @(posedge clk); #1;
        chk_reset_outputs("t6_held");
        resetn = 1'b1;
        tick();
        mon_en = 1;
        repeat (3) tick();
        chk("t6_in_level", 32'(in_level), 32'(0));
        chk("t6_no_val", 32'(dev_input_val), 32'(0));

        // Randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            ld_val = ($urandom_range(0, 2) == 0);
            ld_data = DW'($urandom);
            dev_input_rdy = ($urandom_range(0, 1) == 1);
            cap_pop = ($urandom_range(0, 3) == 0);
            if (!dev_output_rdy) begin
                if ($urandom_range(0, 3) == 0) begin
                    dev_output_data = DW'($urandom);
                    dev_output_rdy = 1'b1;
                    out_acked = 0;
                end
            end else if (out_acked) begin
                if ($urandom_range(0, 1) == 0) dev_output_rdy = 1'b0;
            end else if ($urandom_range(0, 15) == 0) begin
                dev_output_rdy = 1'b0;
            end
            tick();
        end
        ld_val = 1'b0; cap_pop = 1'b0; dev_output_rdy = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
